arp_sequencer: RTL and testbench
================================

Name: arp_sequencer

Overview:
Parametrised arpeggiator core that generates the sine-table read address for the audio path, replacing the hard-wired four-note up-only arpeggiator logic in the top level. It steps through a configurable number of major-chord intervals in selectable patterns (up, down, up-down, hold), derives each note's clock-divider period from a base period, and advances a wrapping table address at that rate. Its address feeds the sine BRAM; the BRAM output goes to the PWM module.

Parameters:
ADDR_W, 8, sine-table address width; address wraps modulo 2^ADDR_W
DIV_W, 13, width of base_period, period and divider counter
STEP_W, 27, width of the note-duration counter
STEP_CYCLES, 50000000, clock cycles per arpeggio note; legal range 1..2^STEP_W-1
NUM_NOTES, 4, chord length, legal 1..4; uses the first NUM_NOTES intervals of {tonic, major third, fifth, octave}

Ports:
clock  in  1  system clock; every register is clocked on its rising edge
reset  in  1  synchronous, active-high reset
base_period  in  DIV_W  tonic divider period, in clock cycles
toggle  in  1  one-cycle pulse, already debounced; toggles arpeggiator on/off
mode  in  2  0 up, 1 down, 2 up-down, 3 hold
addr  out  ADDR_W  sine-table read address
addr_step  out  1  one-cycle pulse on each cycle where addr advances
note  out  2  current note index, for the LEDs
period  out  DIV_W  current note's divider period
arp_active  out  1  arpeggiator state

Behaviour:
- Reset (synchronous, wins over every other input): addr=0, addr_step=0, note=0, period=0, arp_active=0, divider counter=0, step counter=0, direction=up.
- toggle=1: arp_active inverts next cycle. On entry to active: note=0, step counter=0, direction=up. While inactive: note held at 0, step counter held at 0.
- Step counter (active only): increments each cycle. At STEP_CYCLES-1 it clears and the note advances per mode, so each note lasts exactly STEP_CYCLES cycles.
  - up: 0..N-1, then wraps to 0.
  - down: N-1..0, then wraps to N-1.
  - up-down: ping-pong with no repeated endpoints (0,1,2,3,2,1,0,1...). Direction flips at 0 and N-1. With N=1, note stays 0.
  - hold: note unchanged.
  - A mode change is sampled only at an advance. If the note is out of range for the new mode, the normal wrap rule applies.
- Period, registered; it reflects the note one cycle later:
  - note0: base
  - note1: floor(base*4/5)
  - note2: floor(base*2/3)
  - note3: base>>1
  - Intermediates are DIV_W+3 bits and the result is truncated to DIV_W with no overflow.
- Divider: the counter increments each cycle. When counter >= period, the counter clears to 0, addr increments (mod 2^ADDR_W), and addr_step=1 for that cycle. Each address step therefore takes period+1 cycles.
  - The >= compare is mandatory: when period drops below the counter, the advance happens on the next cycle, with no wrap-around stall.
  - period=0 means addr advances every cycle.
- The divider runs in both active and inactive states. When inactive, the tone is the base note.
- No output is combinational from inputs.

Optional Feature:
LATCH_BASE_EN
- Defined: base_period is sampled into an internal register only on reset release, on activation, and on each note advance. Changes between those points do not affect period until the next sample point.
- Undefined: base_period is used live, and period tracks it with one cycle of latency.

Test Plan:
1. reset held 3 cycles with toggle=1 -> arp_active=0, addr=0, note=0 after release. Then base_period=10, arp off -> addr increments every 11 cycles and addr_step pulses one cycle each time.
2. STEP_CYCLES=8, N=4, mode=0, base=10, toggle pulse -> notes 0,1,2,3,0 each held 8 cycles; period 10,8,6,5,10, each one cycle after its note change.
3. Same configuration, mode=2 -> note sequence 0,1,2,3,2,1,0,1. Mode=1 -> 3,2,1,0,3 after the first advance from 0. Mode=3 -> note stays constant.
4. Toggle pulse mid-note while active -> arp_active=0 and note=0 next cycle, step counter cleared. A second toggle restarts at note 0 with a full 8-cycle duration.
5. base=10, divider counter at 9, note advances to period 5 -> addr advances on the cycle after period updates (counter >= period); no 8192-cycle stall.
6. addr=255 with ADDR_W=8 -> next advance gives addr=0 with addr_step=1. With LATCH_BASE_EN, base changed mid-note -> period unchanged until the next note advance.

Source files
------------

// File: rtl/arp_sequencer.sv
// ============================================================================
// arp_sequencer : chord arpeggiator driving the sine-table read address.
// Optional macro LATCH_BASE_EN: sample base_period only at note boundaries.
// Revision: 1.0
// ============================================================================
`default_nettype none

module arp_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int DIV_W       = 13,
    parameter int STEP_W      = 27,
    parameter int STEP_CYCLES = 50000000,
    parameter int NUM_NOTES   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DIV_W-1:0]  base_period,
    input  logic              toggle,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_step,
    output logic [1:0]        note,
    output logic [DIV_W-1:0]  period,
    output logic              arp_active
);

    localparam int                c_EXT_W     = DIV_W + 3;
    localparam logic [STEP_W-1:0] c_STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [1:0]        c_NOTE_LAST = 2'(NUM_NOTES - 1);
    localparam logic [c_EXT_W-1:0] c_FIVE     = c_EXT_W'(5);
    localparam logic [c_EXT_W-1:0] c_THREE    = c_EXT_W'(3);

    typedef enum logic {ST_IDLE = 1'b0, ST_ARP = 1'b1} state_t;
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    state_t              r_state;
    dir_t                r_dir;
    logic [1:0]          r_note;
    logic [STEP_W-1:0]   r_step;
    logic [DIV_W-1:0]    r_period;
    logic [DIV_W-1:0]    r_div;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_addr_step;

    logic [DIV_W-1:0]    w_base;
    logic [c_EXT_W-1:0]  w_base_ext;
    logic [c_EXT_W-1:0]  w_p1_ext;
    logic [c_EXT_W-1:0]  w_p2_ext;
    logic [DIV_W-1:0]    w_period_next;
    logic [1:0]          w_next_note;
    dir_t                w_next_dir;
    logic                w_advance;

`ifdef LATCH_BASE_EN
    logic [DIV_W-1:0]    r_base;
    assign w_base = r_base;
`else
    assign w_base = base_period;
`endif

    assign w_advance = (r_state == ST_ARP) && !toggle && (r_step >= c_STEP_LAST);

    // Next note for the current pattern; out-of-range notes fall into the wrap rule
    always_comb begin
        w_next_note = r_note;
        w_next_dir  = r_dir;
        case (mode)
            2'd0: w_next_note = (r_note >= c_NOTE_LAST) ? 2'd0 : r_note + 2'd1;
            2'd1: w_next_note = (r_note == 2'd0 || r_note > c_NOTE_LAST) ? c_NOTE_LAST
                                                                         : r_note - 2'd1;
            2'd2: begin
                if (c_NOTE_LAST != 2'd0) begin
                    if (r_dir == DIR_UP) begin
                        if (r_note >= c_NOTE_LAST) begin
                            w_next_dir  = DIR_DOWN;
                            w_next_note = c_NOTE_LAST - 2'd1;
                        end else begin
                            w_next_note = r_note + 2'd1;
                        end
                    end else begin
                        if (r_note == 2'd0) begin
                            w_next_dir  = DIR_UP;
                            w_next_note = 2'd1;
                        end else begin
                            w_next_note = r_note - 2'd1;
                        end
                    end
                end else begin
                    w_next_note = 2'd0;
                end
            end
            default: w_next_note = r_note;
        endcase
    end

    assign w_base_ext = {3'b000, w_base};
    assign w_p1_ext   = (w_base_ext << 2) / c_FIVE;
    assign w_p2_ext   = (w_base_ext << 1) / c_THREE;

    always_comb begin
        w_period_next = w_base;
        case (r_note)
            2'd0:    w_period_next = w_base;
            2'd1:    w_period_next = w_p1_ext[DIV_W-1:0];
            2'd2:    w_period_next = w_p2_ext[DIV_W-1:0];
            default: w_period_next = w_base >> 1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_note  <= 2'd0;
            r_step  <= '0;
            r_dir   <= DIR_UP;
`ifdef LATCH_BASE_EN
            r_base  <= base_period;
`endif
        end else if (toggle) begin
            r_note <= 2'd0;
            r_step <= '0;
            if (r_state == ST_IDLE) begin
                r_state <= ST_ARP;
                r_dir   <= DIR_UP;
`ifdef LATCH_BASE_EN
                r_base  <= base_period;
`endif
            end else begin
                r_state <= ST_IDLE;
            end
        end else if (r_state == ST_ARP) begin
            if (w_advance) begin
                r_step <= '0;
                r_note <= w_next_note;
                r_dir  <= w_next_dir;
`ifdef LATCH_BASE_EN
                r_base <= base_period;
`endif
            end else begin
                r_step <= r_step + STEP_W'(1);
            end
        end else begin
            r_note <= 2'd0;
            r_step <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_period <= '0;
        end else begin
            r_period <= w_period_next;
        end
    end

    // >= rather than == so a period drop below the running count never stalls
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div       <= '0;
            r_addr      <= '0;
            r_addr_step <= 1'b0;
        end else if (r_div >= r_period) begin
            r_div       <= '0;
            r_addr      <= r_addr + ADDR_W'(1);
            r_addr_step <= 1'b1;
        end else begin
            r_div       <= r_div + DIV_W'(1);
            r_addr_step <= 1'b0;
        end
    end

    assign addr       = r_addr;
    assign addr_step  = r_addr_step;
    assign note       = r_note;
    assign period     = r_period;
    assign arp_active = (r_state == ST_ARP);

endmodule

`default_nettype wire

// File: tb/tb_arp_sequencer.sv
// ============================================================================
// tb_arp_sequencer : randomized scoreboard bench for arp_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_arp_sequencer;

    localparam int ADDR_W      = 8;
    localparam int DIV_W       = 13;
    localparam int STEP_W      = 27;
    localparam int STEP_CYCLES = 8;
    localparam int NUM_NOTES   = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              toggle;
    logic [1:0]        mode;
    logic [DIV_W-1:0]  base_period;
    logic [ADDR_W-1:0] addr;
    logic              addr_step;
    logic [1:0]        note;
    logic [DIV_W-1:0]  period;
    logic              arp_active;

    arp_sequencer #(
        .ADDR_W      (ADDR_W),
        .DIV_W       (DIV_W),
        .STEP_W      (STEP_W),
        .STEP_CYCLES (STEP_CYCLES),
        .NUM_NOTES   (NUM_NOTES)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .base_period (base_period),
        .toggle      (toggle),
        .mode        (mode),
        .addr        (addr),
        .addr_step   (addr_step),
        .note        (note),
        .period      (period),
        .arp_active  (arp_active)
    );

    always #5 clock = ~clock;

    typedef struct {
        int addr;
        int addr_step;
        int note;
        int period;
        int active;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state, in plain integers
    int m_active, m_note, m_up, m_step, m_div, m_addr, m_astep, m_period, m_base;

    function automatic int period_of(input int n, input int b);
        int r;
        case (n)
            0:       r = b;
            1:       r = (b * 4) / 5;
            2:       r = (b * 2) / 3;
            default: r = b / 2;
        endcase
        return r % (1 << DIV_W);
    endfunction

    always @(posedge clock) begin
        exp_t e;
        int   eb;
        int   np;
        if (reset) begin
            m_active = 0; m_note = 0; m_up = 1; m_step = 0;
            m_div = 0; m_addr = 0; m_astep = 0; m_period = 0;
            m_base = int'(base_period);
        end else begin
`ifdef LATCH_BASE_EN
            eb = m_base;
`else
            eb = int'(base_period);
`endif
            np = period_of(m_note, eb);
            if (m_div >= m_period) begin
                m_div = 0;
                m_addr = (m_addr + 1) % (1 << ADDR_W);
                m_astep = 1;
            end else begin
                m_div = m_div + 1;
                m_astep = 0;
            end
            m_period = np;
            if (toggle) begin
                m_active = 1 - m_active;
                m_note = 0;
                m_step = 0;
                if (m_active == 1) begin
                    m_up = 1;
                    m_base = int'(base_period);
                end
            end else if (m_active == 1) begin
                if (m_step == STEP_CYCLES - 1) begin
                    m_step = 0;
                    m_base = int'(base_period);
                    case (mode)
                        2'd0: m_note = (m_note + 1) % NUM_NOTES;
                        2'd1: m_note = (m_note + NUM_NOTES - 1) % NUM_NOTES;
                        2'd2: begin
                            if (NUM_NOTES > 1) begin
                                if (m_up == 1) begin
                                    if (m_note == NUM_NOTES - 1) begin m_up = 0; m_note = m_note - 1; end
                                    else m_note = m_note + 1;
                                end else begin
                                    if (m_note == 0) begin m_up = 1; m_note = 1; end
                                    else m_note = m_note - 1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    m_step = m_step + 1;
                end
            end else begin
                m_note = 0;
                m_step = 0;
            end
        end
        e.addr = m_addr; e.addr_step = m_astep; e.note = m_note;
        e.period = m_period; e.active = m_active;
        sb.push_back(e);
    end

    task automatic check(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp_v);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard at %0t: got empty queue, expected an entry", $time);
        end else begin
            e = sb.pop_front();
            check("addr",       int'(addr),       e.addr);
            check("addr_step",  int'(addr_step),  e.addr_step);
            check("note",       int'(note),       e.note);
            check("period",     int'(period),     e.period);
            check("arp_active", int'(arp_active), e.active);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_toggle();
        toggle = 1'b1;
        cyc(1);
        toggle = 1'b0;
    endtask

    initial begin
        reset = 1'b1; toggle = 1'b1; mode = 2'd0; base_period = 13'd10;
        cyc(3);
        reset = 1'b0; toggle = 1'b0;
        cyc(40);                            // free-running base tone while off
        pulse_toggle();
        cyc(60);                            // up pattern
        mode = 2'd2; cyc(80);               // up-down
        mode = 2'd1; cyc(60);               // down
        mode = 2'd3; cyc(30);               // hold
        mode = 2'd0; cyc(3);
        pulse_toggle(); cyc(5);             // stop mid-note
        pulse_toggle(); cyc(30);            // restart
        base_period = 13'd8191; cyc(60);    // widest base
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) toggle = 1'b1;
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0)
                base_period = ($urandom_range(0, 3) == 0) ? DIV_W'($urandom)
                                                          : DIV_W'($urandom_range(0, 20));
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
            cyc(1);
            toggle = 1'b0;
            reset = 1'b0;
        end
        base_period = 13'd0; cyc(300);      // every-cycle stepping, repeated wraps
        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
